inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage inside cpu. Drives RAM port A (read-only, synchronous, 1-cycle read latency) with a byte PC and captures returned words into a small instruction queue. Presents instructions with their PCs to decode through a valid/ready handshake. Accepts PC redirects from branch/jump resolution, which flush all fetched and in-flight instructions.

Parameters:
ADDR_WIDTH, 32, width of PC / mem_addr_a
INST_WIDTH, 32, instruction width (= mem_data_a width)
QUEUE_DEPTH, 4, instruction queue entries; power of 2, >= 2
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  reset, asynchronous, active-high
mem_addr_a  output  ADDR_WIDTH  byte address to RAM port A; equals fetch_pc register
mem_data_a  input  INST_WIDTH  RAM port A read data; valid the cycle after address is sampled
jump_valid  input  1  redirect request, sampled at rising edge
jump_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored, forced 00
out_valid  output  1  queue non-empty
out_inst  output  INST_WIDTH  instruction at queue head
out_pc  output  ADDR_WIDTH  PC of out_inst
out_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst_in high, any time, async): fetch_pc=RESET_PC; inflight=0; queue empty (head=tail=0, count=0); out_valid=0; out_inst=0; out_pc=0; mem_addr_a=RESET_PC. Queue storage is not reset.
- out_inst/out_pc gated to 0 whenever out_valid=0.
- Issue: at an edge with no jump_valid and (count + inflight) < QUEUE_DEPTH -> inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. Otherwise inflight<=0, fetch_pc held. Occupancy is counted conservatively; a same-edge pop does not free a slot.
- Capture: at an edge with inflight=1 and no jump_valid -> push {mem_data_a, inflight_pc} at tail.
- Pop: at an edge with out_valid && out_ready and no jump_valid -> head advances.
- Push+pop on same edge: count unchanged, both pointers advance.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFFFC+4 -> 0x00000000.
- Redirect (jump_valid=1 at edge J) has priority over issue, capture and pop:
  - Queue cleared; inflight<=0, so the response arriving after J is discarded.
  - fetch_pc<=jump_pc & ~3.
  - Issue of the target happens at J+1. Capture at J+2. out_valid=1 after J+2.
  - A handshake asserted in cycle J is void; decode is flushed by the same redirect.
- Latency: first instruction after reset release has out_valid=1 after the 2nd rising edge. Redirect-to-valid takes 2 edges after J. Steady state with out_ready=1 delivers 1 instruction/cycle.
- Full: with out_ready=0, issue stops once count+inflight=QUEUE_DEPTH. No entry is ever lost or overwritten.

Decomposition:
- Shared cpu package: INST_BYTES=4, RESET_PC default, ADDR_WIDTH/INST_WIDTH constants.
- Sub-module inst_queue:
  - Circular FIFO of {inst, pc} with push, pop, flush, count.
  - Flush dominates push and pop.
  - inst_fetch holds the PC/inflight logic.

Test Plan:
- Reset release, RAM words 0x00000013@0, 0x00100093@4, out_ready=1 -> out_valid rises after edge 2 with out_pc=0, out_inst=0x00000013; next cycle out_pc=4, out_inst=0x00100093; continuous 1/cycle.
- out_ready=0 from reset -> exactly 4 entries queued, mem_addr_a stalls at 0x10; raise out_ready -> pops PCs 0,4,8,C in order with no gaps or duplicates.
- jump_valid with jump_pc=0x103 while queue holds 3 entries and one in flight -> out_valid=0 for 2 cycles, then out_pc=0x100; no pre-jump PC ever appears.
- Back-to-back jump_valid on two edges (0x40 then 0x80) -> first target discarded, first output out_pc=0x80.
- rst_in pulsed asynchronously mid-stream (between edges) -> outputs zero and mem_addr_a=RESET_PC immediately; restart matches scenario 1.
- RESET_PC=0xFFFFFFF8, out_ready=1 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared cpu constants used by the fetch stage and its instruction queue.
package inst_fetch_pkg;
  localparam int          CPU_ADDR_WIDTH = 32;
  localparam int          CPU_INST_WIDTH = 32;
  localparam int          INST_BYTES     = 4;
  localparam logic [31:0] CPU_RESET_PC   = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_queue.sv
// Circular FIFO of {inst, pc} pairs; flush empties it and overrides push/pop.
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int INST_WIDTH  = CPU_INST_WIDTH,
  parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush,
  input  logic                         push,
  input  logic [INST_WIDTH-1:0]        push_inst,
  input  logic [ADDR_WIDTH-1:0]        push_pc,
  input  logic                         pop,
  output logic [INST_WIDTH-1:0]        head_inst,
  output logic [ADDR_WIDTH-1:0]        head_pc,
  output logic [$clog2(QUEUE_DEPTH):0] count
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_WIDTH-1:0] inst_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  push_eff;
  logic                  pop_eff;

  assign push_eff = push && !flush && (count != CNT_W'(QUEUE_DEPTH));
  assign pop_eff  = pop  && !flush && (count != '0);

  // Storage carries data only and is never reset.
  always_ff @(posedge clk_in) begin
    if (push_eff) begin
      inst_mem[tail] <= push_inst;
      pc_mem[tail]   <= push_pc;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_eff) tail <= tail + PTR_W'(1);
      if (pop_eff)  head <= head + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_inst = inst_mem[head];
  assign head_pc   = pc_mem[head];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues byte PCs to a 1-cycle RAM, queues returned words, redirects on jump.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = CPU_ADDR_WIDTH,
  parameter int                    INST_WIDTH  = CPU_INST_WIDTH,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(CPU_RESET_PC)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  input  logic [INST_WIDTH-1:0] mem_data_a,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_pc,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc & ~ADDR_WIDTH'(INST_BYTES - 1);
  endfunction

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      occupancy;
  logic                  issue;
  logic                  capture;
  logic [INST_WIDTH-1:0] head_inst;
  logic [ADDR_WIDTH-1:0] head_pc;

  // In-flight reads reserve a slot so a returning word always has room.
  assign occupancy = count + CNT_W'(inflight);
  assign issue     = !jump_valid && (occupancy < CNT_W'(QUEUE_DEPTH));
  assign capture   = inflight && !jump_valid;

  // Stage 0: address issue to RAM port A
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (jump_valid) begin
      fetch_pc <= align_pc(jump_pc);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue) inflight_pc <= fetch_pc;
  end

  assign mem_addr_a = fetch_pc;

  // Stage 1: RAM data returns and is captured into the queue
  inst_queue #(
    .INST_WIDTH (INST_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush    (jump_valid),
    .push     (capture),
    .push_inst(mem_data_a),
    .push_pc  (inflight_pc),
    .pop      (out_valid && out_ready),
    .head_inst(head_inst),
    .head_pc  (head_pc),
    .count    (count)
  );

  assign out_valid = (count != '0);
  assign out_inst  = out_valid ? head_inst : '0;
  assign out_pc    = out_valid ? head_pc   : '0;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a synchronous 1-cycle RAM model per instance.
module tb_inst_fetch;
  logic        clk;
  logic        rst;
  logic        jv;
  logic [31:0] jpc;
  logic        rdy;
  logic [31:0] addr, data;
  logic        vld;
  logic [31:0] inst, pc;

  logic        rdy_w;
  logic [31:0] addr_w, data_w;
  logic        vld_w;
  logic [31:0] inst_w, pc_w;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  inst_fetch u_dut (
    .clk_in(clk), .rst_in(rst), .mem_addr_a(addr), .mem_data_a(data),
    .jump_valid(jv), .jump_pc(jpc), .out_valid(vld), .out_inst(inst),
    .out_pc(pc), .out_ready(rdy)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
    .clk_in(clk), .rst_in(rst), .mem_addr_a(addr_w), .mem_data_a(data_w),
    .jump_valid(1'b0), .jump_pc(32'h0), .out_valid(vld_w), .out_inst(inst_w),
    .out_pc(pc_w), .out_ready(rdy_w)
  );

  always @(posedge clk) begin
    data   <= mem_word(addr);
    data_w <= mem_word(addr_w);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; jv = 1'b0; jpc = '0; rdy = 1'b1; rdy_w = 1'b1;
    tick();
    chk("rst_valid", {31'd0, vld}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_addr_w", addr_w, 32'hFFFF_FFF8);

    // Scenario 1: stream from reset with decode always ready
    rst = 1'b0;
    tick();
    chk("s1_e1_valid", {31'd0, vld}, 32'd0);
    chk("s1_e1_addr", addr, 32'h4);
    tick();
    chk("s1_e2_valid", {31'd0, vld}, 32'd1);
    chk("s1_e2_pc", pc, 32'h0);
    chk("s1_e2_inst", inst, 32'h0000_0013);
    chk("wrap_pc0", pc_w, 32'hFFFF_FFF8);
    tick();
    chk("s1_e3_pc", pc, 32'h4);
    chk("s1_e3_inst", inst, 32'h0010_0093);
    chk("wrap_pc1", pc_w, 32'hFFFF_FFFC);
    tick();
    chk("s1_e4_pc", pc, 32'h8);
    chk("s1_e4_inst", inst, 32'hDEAD_0008);
    chk("wrap_pc2", pc_w, 32'h0000_0000);
    chk("wrap_valid", {31'd0, vld_w}, 32'd1);
    tick();
    chk("s1_e5_pc", pc, 32'hC);

    // Scenario 2: decode stalled from reset fills the queue
    rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("s2_full_addr", addr, 32'h10);
    chk("s2_full_valid", {31'd0, vld}, 32'd1);
    chk("s2_full_pc", pc, 32'h0);
    rdy = 1'b1;
    tick();
    chk("s2_pop_pc4", pc, 32'h4);
    tick();
    chk("s2_pop_pc8", pc, 32'h8);
    tick();
    chk("s2_pop_pcC", pc, 32'hC);
    tick();
    chk("s2_pop_pc10", pc, 32'h10);
    chk("s2_pop_valid", {31'd0, vld}, 32'd1);

    // Scenario 3: redirect with three queued and one in flight
    rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("s3_pre_pc", pc, 32'h0);
    jv = 1'b1; jpc = 32'h103; rdy = 1'b1;
    tick();
    jv = 1'b0;
    chk("s3_j_valid", {31'd0, vld}, 32'd0);
    chk("s3_j_addr", addr, 32'h100);
    tick();
    chk("s3_j1_valid", {31'd0, vld}, 32'd0);
    tick();
    chk("s3_j2_valid", {31'd0, vld}, 32'd1);
    chk("s3_j2_pc", pc, 32'h100);
    tick();
    chk("s3_j3_pc", pc, 32'h104);

    // Scenario 4: back-to-back redirects, the second wins
    jv = 1'b1; jpc = 32'h40;
    tick();
    chk("s4_j1_addr", addr, 32'h40);
    jpc = 32'h80;
    tick();
    jv = 1'b0;
    chk("s4_j2_addr", addr, 32'h80);
    chk("s4_j2_valid", {31'd0, vld}, 32'd0);
    tick();
    chk("s4_j3_valid", {31'd0, vld}, 32'd0);
    tick();
    chk("s4_first_pc", pc, 32'h80);
    tick();
    chk("s4_second_pc", pc, 32'h84);

    // Scenario 5: asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("s5_async_valid", {31'd0, vld}, 32'd0);
    chk("s5_async_inst", inst, 32'h0);
    chk("s5_async_pc", pc, 32'h0);
    chk("s5_async_addr", addr, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("s5_e1_valid", {31'd0, vld}, 32'd0);
    tick();
    chk("s5_e2_pc", pc, 32'h0);
    chk("s5_e2_inst", inst, 32'h0000_0013);
    tick();
    chk("s5_e3_pc", pc, 32'h4);
    chk("s5_e3_inst", inst, 32'h0010_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
